ucaspian_tx_encoder: RTL and testbench
======================================

Name: ucaspian_tx_encoder

Overview:
Downstream of the core. Collects the core's outbound events (output fires, time updates, metric replies, clear and config acknowledgements) and serialises them into byte packets on a single valid/ready byte stream toward the I/O interface. Arbitration uses fixed priority. Each packet's payload is captured at selection. The core's sent/ack handshakes complete only after the whole packet has left.

Parameters:
OP_FIRE, 8'h41, opcode byte of an output-fire packet
OP_TIME, 8'h42, opcode byte of a time-update packet
OP_METRIC, 8'h43, opcode byte of a metric-reply packet
OP_CLEAR, 8'h44, opcode byte of a clear-ack packet
OP_CONFIG, 8'h45, opcode byte of a config-ack packet

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
output_fire_addr  in  8  address of the neuron that fired
output_fire_waiting  in  1  a fire is pending (level)
output_fire_sent  out  1  one-cycle pulse: fire packet fully transmitted
time_current  in  32  core time
time_update  in  1  a time update is pending (level)
time_sent  out  1  one-cycle pulse: time packet fully transmitted
metric_value  in  8  metric data byte
metric_addr  in  8  metric address being answered
metric_send  in  1  pulse: metric_value/metric_addr are valid this cycle
metric_pending  out  1  a metric is buffered and not yet sent
clear_done  in  1  clear acknowledge (level)
ack_sent  out  1  one-cycle pulse: clear-ack packet transmitted
config_done  in  1  config acknowledge (level, may stay high several cycles)
tx_data  out  8  outbound byte
tx_vld  out  1  tx_data valid
tx_rdy  in  1  consumer accepts the byte when tx_vld && tx_rdy

Behaviour:
- Reset values: tx_vld=0, tx_data=0, all *_sent/ack_sent=0, metric_pending=0. Also reset: cfg_pend=0, cfg_prev=0, state=IDLE.
- Reset mid-packet: the partial packet is abandoned, no sent pulse is issued, and all pending flags are cleared.
- Event capture:
  - metric_send with metric_pending=0 latches metric_addr and metric_value and sets metric_pending.
  - metric_send with metric_pending=1 is dropped.
  - config_done rising edge (config_done && !cfg_prev) sets cfg_pend.
  - fire, time and clear are taken from their level inputs and not latched.
- Packet formats, byte order as transmitted:
  - FIRE: OP_FIRE, addr (2 bytes)
  - TIME: OP_TIME, t[31:24], t[23:16], t[15:8], t[7:0] (5 bytes)
  - METRIC: OP_METRIC, addr, value (3 bytes)
  - CLEAR: OP_CLEAR (1 byte)
  - CONFIG: OP_CONFIG (1 byte)
- FSM states IDLE, SEND, ACK.
- IDLE: selects the highest-priority pending source in the order CLEAR (clear_done) > CONFIG (cfg_pend) > METRIC (metric_pending) > FIRE (output_fire_waiting) > TIME (time_update).
  - On selection it loads a payload shift register (fire addr, or time_current sampled in that cycle, or metric addr/value), sets the byte count and kind, and goes to SEND.
  - tx_vld rises the cycle after selection.
- SEND: tx_vld=1 and tx_data is held stable until tx_vld && tx_rdy.
  - On each accept, advance to the next byte. tx_vld stays high back-to-back when further bytes remain, giving 1 byte per cycle with tx_rdy=1.
  - On accept of the last byte: tx_vld=0, go to ACK.
- ACK (exactly 1 cycle):
  - Pulse the matching output: output_fire_sent, time_sent or ack_sent.
  - METRIC clears metric_pending at the exit of ACK.
  - CONFIG clears cfg_pend at the exit of ACK; a new config edge in that same cycle re-sets it.
  - Then go to IDLE.
  - ACK exists so the core's registered waiting/update/clear_done deassert before IDLE re-samples, which prevents a duplicate packet.
- Latency at tx_rdy=1: event in IDLE -> first byte 1 cycle later. An N-byte packet occupies 1+N+1 cycles from selection to return to IDLE.
- Non-preemption: a packet in flight is never preempted; higher-priority events wait in IDLE arbitration.
- Output timing: outputs are registered; there is no combinational path from tx_rdy to tx_vld or tx_data.

Test Plan:
- Fire: output_fire_waiting=1, addr=0x2A, tx_rdy=1 -> bytes 0x41,0x2A on consecutive cycles; output_fire_sent single pulse in the following cycle; exactly one packet.
- Time with backpressure: time_current=0x01020304 with time_update=1, tx_rdy toggling 1/0 -> bytes 0x42,01,02,03,04. tx_data is stable while tx_rdy=0. time_sent pulses once after the final accept.
- Priority: clear_done, output_fire_waiting and time_update all asserted in the same cycle -> 0x44 then ack_sent; next 0x41,addr; then the time packet.
- Metric: metric_send with addr=7, value=0x9C -> 0x43,0x07,0x9C and metric_pending=1 until ACK. A second metric_send during the packet is dropped, not sent.
- Config: config_done held high 4 cycles -> exactly one 0x45 byte.
- Reset: reset asserted during byte 3 of a time packet -> tx_vld=0 next cycle, no time_sent pulse, metric_pending=0. A re-asserted time_update afterward yields a full 5-byte packet.

Source files
------------

// File: rtl/ucaspian_tx_encoder.sv
// Serialises core outbound events (clear/config acks, metric replies, output
// fires, time updates) into byte packets on one valid/ready byte stream.
module ucaspian_tx_encoder #(
  parameter logic [7:0] OP_FIRE   = 8'h41,
  parameter logic [7:0] OP_TIME   = 8'h42,
  parameter logic [7:0] OP_METRIC = 8'h43,
  parameter logic [7:0] OP_CLEAR  = 8'h44,
  parameter logic [7:0] OP_CONFIG = 8'h45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  output_fire_addr,
  input  logic        output_fire_waiting,
  output logic        output_fire_sent,
  input  logic [31:0] time_current,
  input  logic        time_update,
  output logic        time_sent,
  input  logic [7:0]  metric_value,
  input  logic [7:0]  metric_addr,
  input  logic        metric_send,
  output logic        metric_pending,
  input  logic        clear_done,
  output logic        ack_sent,
  input  logic        config_done,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy
);

  // tx stream: a byte transfers on a clock edge where tx_vld && tx_rdy; once
  // raised, tx_vld and tx_data hold until that transfer happens.
  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;
  typedef enum logic [2:0] {K_FIRE, K_TIME, K_METRIC, K_CLEAR, K_CONFIG} kind_t;

  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic [31:0] shreg, shreg_n;
  logic [2:0]  rem, rem_n;
  logic [7:0]  tx_data_n;
  logic        tx_vld_n;
  logic        fire_sent_n, time_sent_n, ack_sent_n;
  logic        metric_pending_n;
  logic [7:0]  m_addr, m_addr_n, m_val, m_val_n;
  logic        cfg_pend, cfg_pend_n, cfg_prev;

  always_comb begin
    state_n          = state;
    kind_n           = kind;
    shreg_n          = shreg;
    rem_n            = rem;
    tx_data_n        = tx_data;
    tx_vld_n         = tx_vld;
    fire_sent_n      = 1'b0;
    time_sent_n      = 1'b0;
    ack_sent_n       = 1'b0;
    metric_pending_n = metric_pending;
    m_addr_n         = m_addr;
    m_val_n          = m_val;
    cfg_pend_n       = cfg_pend;

    if (metric_send && !metric_pending) begin
      metric_pending_n = 1'b1;
      m_addr_n         = metric_addr;
      m_val_n          = metric_value;
    end

    case (state)
      IDLE: begin
        state_n  = SEND;
        tx_vld_n = 1'b1;
        if (clear_done) begin
          kind_n    = K_CLEAR;
          tx_data_n = OP_CLEAR;
          rem_n     = 3'd0;
        end else if (cfg_pend) begin
          kind_n    = K_CONFIG;
          tx_data_n = OP_CONFIG;
          rem_n     = 3'd0;
        end else if (metric_pending) begin
          kind_n    = K_METRIC;
          tx_data_n = OP_METRIC;
          shreg_n   = {m_addr, m_val, 16'h0000};
          rem_n     = 3'd2;
        end else if (output_fire_waiting) begin
          kind_n    = K_FIRE;
          tx_data_n = OP_FIRE;
          shreg_n   = {output_fire_addr, 24'h000000};
          rem_n     = 3'd1;
        end else if (time_update) begin
          kind_n    = K_TIME;
          tx_data_n = OP_TIME;
          shreg_n   = time_current;
          rem_n     = 3'd4;
        end else begin
          state_n  = IDLE;
          tx_vld_n = 1'b0;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          if (rem == 3'd0) begin
            // Pulses are registered so they are high during the ACK cycle.
            tx_vld_n = 1'b0;
            state_n  = ACK;
            case (kind)
              K_FIRE:  fire_sent_n = 1'b1;
              K_TIME:  time_sent_n = 1'b1;
              K_CLEAR: ack_sent_n  = 1'b1;
              default: ;
            endcase
          end else begin
            tx_data_n = shreg[31:24];
            shreg_n   = {shreg[23:0], 8'h00};
            rem_n     = rem - 3'd1;
          end
        end
      end
      ACK: begin
        state_n = IDLE;
        if (kind == K_METRIC) metric_pending_n = 1'b0;
        if (kind == K_CONFIG) cfg_pend_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Evaluated last so a config edge during ACK survives the clear above.
    if (config_done && !cfg_prev) cfg_pend_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      kind             <= K_FIRE;
      shreg            <= '0;
      rem              <= '0;
      tx_data          <= '0;
      tx_vld           <= 1'b0;
      output_fire_sent <= 1'b0;
      time_sent        <= 1'b0;
      ack_sent         <= 1'b0;
      metric_pending   <= 1'b0;
      m_addr           <= '0;
      m_val            <= '0;
      cfg_pend         <= 1'b0;
      cfg_prev         <= 1'b0;
    end else begin
      state            <= state_n;
      kind             <= kind_n;
      shreg            <= shreg_n;
      rem              <= rem_n;
      tx_data          <= tx_data_n;
      tx_vld           <= tx_vld_n;
      output_fire_sent <= fire_sent_n;
      time_sent        <= time_sent_n;
      ack_sent         <= ack_sent_n;
      metric_pending   <= metric_pending_n;
      m_addr           <= m_addr_n;
      m_val            <= m_val_n;
      cfg_pend         <= cfg_pend_n;
      cfg_prev         <= config_done;
    end
  end

endmodule

// File: tb/tb_ucaspian_tx_encoder.sv
// Directed bench for ucaspian_tx_encoder: a vector table of single packets plus
// hand sequences for priority, metric drop, config edge and mid-packet reset.
module tb_ucaspian_tx_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  output_fire_addr;
  logic        output_fire_waiting;
  logic        output_fire_sent;
  logic [31:0] time_current;
  logic        time_update;
  logic        time_sent;
  logic [7:0]  metric_value;
  logic [7:0]  metric_addr;
  logic        metric_send;
  logic        metric_pending;
  logic        clear_done;
  logic        ack_sent;
  logic        config_done;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;

  ucaspian_tx_encoder dut (
    .clk(clk), .reset(reset),
    .output_fire_addr(output_fire_addr), .output_fire_waiting(output_fire_waiting),
    .output_fire_sent(output_fire_sent),
    .time_current(time_current), .time_update(time_update), .time_sent(time_sent),
    .metric_value(metric_value), .metric_addr(metric_addr), .metric_send(metric_send),
    .metric_pending(metric_pending),
    .clear_done(clear_done), .ack_sent(ack_sent), .config_done(config_done),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic        time_ev;
    logic [7:0]  addr;
    logic [31:0] t;
    logic        toggle;
    int          n;
    logic [39:0] exp_bytes;
  } vec_t;

  int         chk_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         fire_cnt = 0, time_cnt = 0, ack_cnt = 0;
  logic       toggle_rdy = 1'b0;
  vec_t       vecs[5];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tx_rdy driver: constant 1 or alternating each cycle.
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_rdy = toggle_rdy ? ~tx_rdy : 1'b1;
    end
  end

  // Monitor at negedge: record bytes that will be accepted at the next edge,
  // count pulses, and check tx_data/tx_vld hold under backpressure.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] held = '0;
    forever begin
      @(negedge clk);
      if (hold) begin
        check("hold_vld", {39'd0, tx_vld}, 40'd1);
        check("hold_data", {32'd0, tx_data}, {32'd0, held});
      end
      if (tx_vld && tx_rdy) rx_q.push_back(tx_data);
      if (output_fire_sent) fire_cnt++;
      if (time_sent) time_cnt++;
      if (ack_sent) ack_cnt++;
      hold = tx_vld && !tx_rdy && !reset;
      held = tx_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_pulse(input int which, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      case (which)
        0: seen = output_fire_sent;
        1: seen = time_sent;
        default: seen = ack_sent;
      endcase
    end
    if (!seen) begin
      chk_cnt++; err_cnt++;
      $display("FAIL %s: pulse not seen within 80 cycles", name);
    end
  endtask

  task automatic wait_rx(input int n, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      ok = (rx_q.size() >= n);
    end
    if (!ok) begin
      chk_cnt++; err_cnt++;
      $display("FAIL %s: %0d bytes not seen within 80 cycles", name, n);
    end
  endtask

  task automatic check_rx(input string name);
    check({name, "_len"}, 40'(rx_q.size()), 40'(exp_q.size()));
    for (int b = 0; b < exp_q.size() && b < rx_q.size(); b++)
      check($sformatf("%s_b%0d", name, b), {32'd0, rx_q[b]}, {32'd0, exp_q[b]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0, t0, a0;
    vecs[0] = '{1'b1, 1'b0, 8'h2A, 32'h0,        1'b0, 2, 40'h412A000000};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 32'h01020304, 1'b1, 5, 40'h4201020304};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, 32'h0,        1'b1, 2, 40'h41FF000000};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0, 5, 40'h42DEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 2, 40'h4100000000};

    reset = 1'b1;
    output_fire_addr = 8'h00; output_fire_waiting = 1'b0;
    time_current = 32'h0; time_update = 1'b0;
    metric_value = 8'h00; metric_addr = 8'h00; metric_send = 1'b0;
    clear_done = 1'b0; config_done = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_tx_vld", {39'd0, tx_vld}, 40'd0);
    check("rst_tx_data", {32'd0, tx_data}, 40'd0);
    check("rst_pulses", {37'd0, output_fire_sent, time_sent, ack_sent}, 40'd0);
    check("rst_metric_pending", {39'd0, metric_pending}, 40'd0);
    step();
    reset = 1'b0;
    repeat (2) step();
    rx_q.delete();

    // Single-packet table
    for (int i = 0; i < 5; i++) begin
      toggle_rdy = vecs[i].toggle;
      f0 = fire_cnt; t0 = time_cnt;
      for (int b = 0; b < vecs[i].n; b++) exp_q.push_back(vecs[i].exp_bytes[39-8*b -: 8]);
      step();
      output_fire_addr = vecs[i].addr;
      time_current = vecs[i].t;
      output_fire_waiting = vecs[i].fire;
      time_update = vecs[i].time_ev;
      @(negedge clk);
      check($sformatf("v%0d_sel_vld", i), {39'd0, tx_vld}, 40'd0);
      @(negedge clk);
      check($sformatf("v%0d_first_vld", i), {39'd0, tx_vld}, 40'd1);
      check($sformatf("v%0d_first_data", i), {32'd0, tx_data}, {32'd0, vecs[i].exp_bytes[39:32]});
      wait_pulse(vecs[i].fire ? 0 : 1, $sformatf("v%0d_pulse", i));
      output_fire_waiting = 1'b0;
      time_update = 1'b0;
      repeat (6) @(negedge clk);
      check_rx($sformatf("v%0d", i));
      check($sformatf("v%0d_fire_pulses", i), 40'(fire_cnt - f0), {39'd0, vecs[i].fire});
      check($sformatf("v%0d_time_pulses", i), 40'(time_cnt - t0), {39'd0, vecs[i].time_ev});
    end
    toggle_rdy = 1'b0;

    // Priority: clear > fire > time, all raised together
    f0 = fire_cnt; t0 = time_cnt; a0 = ack_cnt;
    step();
    clear_done = 1'b1; output_fire_waiting = 1'b1; output_fire_addr = 8'h5A;
    time_update = 1'b1; time_current = 32'hA0B0C0D0;
    wait_pulse(2, "prio_ack");
    clear_done = 1'b0;
    wait_pulse(0, "prio_fire");
    output_fire_waiting = 1'b0;
    wait_pulse(1, "prio_time");
    time_update = 1'b0;
    repeat (6) @(negedge clk);
    exp_q = '{8'h44, 8'h41, 8'h5A, 8'h42, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    check_rx("prio");
    check("prio_counts", {8'd0, 32'(ack_cnt - a0)}, 40'd1);
    check("prio_fire_cnt", 40'(fire_cnt - f0), 40'd1);
    check("prio_time_cnt", 40'(time_cnt - t0), 40'd1);

    // Metric capture, second request dropped while pending
    step();
    metric_send = 1'b1; metric_addr = 8'h07; metric_value = 8'h9C;
    step();
    metric_send = 1'b0;
    @(negedge clk);
    check("metric_pending_set", {39'd0, metric_pending}, 40'd1);
    wait_rx(1, "metric_b0");
    step();
    metric_send = 1'b1; metric_addr = 8'h55; metric_value = 8'h66;
    step();
    metric_send = 1'b0;
    wait_rx(3, "metric_b2");
    @(negedge clk);
    check("metric_pending_ack", {39'd0, metric_pending}, 40'd1);
    @(negedge clk);
    check("metric_pending_clr", {39'd0, metric_pending}, 40'd0);
    repeat (8) @(negedge clk);
    exp_q = '{8'h43, 8'h07, 8'h9C};
    check_rx("metric");

    // Config level held 4 cycles -> one byte
    step();
    config_done = 1'b1;
    repeat (4) step();
    config_done = 1'b0;
    repeat (10) @(negedge clk);
    exp_q = '{8'h45};
    check_rx("config");

    // Reset during byte 3 of a time packet, with a metric buffered
    t0 = time_cnt;
    step();
    time_current = 32'h11223344; time_update = 1'b1;
    wait_rx(1, "rst_time_b0");
    step();
    metric_send = 1'b1; metric_addr = 8'h01; metric_value = 8'h02;
    step();
    metric_send = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_byte3", {32'd0, tx_data}, 40'h22);
    check("rst_mid_pend_before", {39'd0, metric_pending}, 40'd1);
    @(negedge clk);
    check("rst_mid_vld", {39'd0, tx_vld}, 40'd0);
    check("rst_mid_pend", {39'd0, metric_pending}, 40'd0);
    step();
    reset = 1'b0;
    rx_q.delete();
    wait_pulse(1, "rst_retry_pulse");
    time_update = 1'b0;
    repeat (6) @(negedge clk);
    exp_q = '{8'h42, 8'h11, 8'h22, 8'h33, 8'h44};
    check_rx("rst_retry");
    check("rst_time_pulses", 40'(time_cnt - t0), 40'd1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
